// File: rtl/e603_nice_pkg.sv
// Shared types and default sizing for the NICE coprocessor controller.
package e603_nice_pkg;

  localparam int NICE_ITAG_W      = 3;
  localparam int NICE_OUTS_DEPTH  = 4;
  localparam int NICE_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } nice_state_e;

  typedef struct packed {
    logic [NICE_ITAG_W-1:0] itag;
    logic                   rd_en;
  } nice_tag_t;

endpackage

// File: rtl/e603_nice_tag_fifo.sv
// In-order synchronous FIFO holding {itag, rd_en} of outstanding NICE instructions.
module e603_nice_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/e603_exu_nice_ctrl.sv
// NICE instruction sequencer: dispatch holding register, in-order tag FIFO,
// zero-latency writeback routing and drain handshake. Optional watchdog: E603_NICE_TIMEOUT_EN.
module e603_exu_nice_ctrl
  import e603_nice_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ITAG_W     = NICE_ITAG_W,
  parameter int OUTS_DEPTH = NICE_OUTS_DEPTH
`ifdef E603_NICE_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = NICE_TIMEOUT_CYC
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [31:0]       i_instr,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [XLEN-1:0]   i_rs2,
  input  logic [ITAG_W-1:0] i_itag,
  input  logic              i_rd_en,
  output logic              nice_req_valid,
  input  logic              nice_req_ready,
  output logic [31:0]       nice_req_inst,
  output logic [XLEN-1:0]   nice_req_rs1,
  output logic [XLEN-1:0]   nice_req_rs2,
  input  logic              nice_rsp_valid,
  output logic              nice_rsp_ready,
  input  logic [XLEN-1:0]   nice_rsp_rdat,
  input  logic              nice_rsp_err,
  output logic              o_wbck_valid,
  input  logic              o_wbck_ready,
  output logic [XLEN-1:0]   o_wbck_wdat,
  output logic [ITAG_W-1:0] o_wbck_itag,
  output logic              o_wbck_rd_en,
  output logic              o_wbck_err,
  input  logic              i_drain_req,
  output logic              o_drain_done,
  output logic              o_nice_busy
`ifdef E603_NICE_TIMEOUT_EN
  , output logic            o_nice_timeout
`endif
);

  // state | meaning
  // RUN   | normal dispatch
  // DRAIN | dispatch blocked, waiting for holding reg and FIFO to empty
  // DONE  | pipeline quiesced, o_drain_done asserted until request drops

  localparam int CNT_W = $clog2(OUTS_DEPTH) + 1;

  nice_state_e       state_q, state_d;
  logic              req_vld;
  logic              fire, req_hs, rsp_hs;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [ITAG_W:0]   fifo_head;
  logic              tmo_block;
  logic              idle;

  assign fire   = i_valid & i_ready;
  assign req_hs = req_vld & nice_req_ready;
  assign rsp_hs = nice_rsp_valid & nice_rsp_ready;
  assign idle   = ~req_vld & (fifo_cnt == '0);

  // Full blocks dispatch even when a retire happens this cycle.
  assign i_ready = (state_q == ST_RUN) & ~fifo_full & (~req_vld | nice_req_ready) & ~tmo_block;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_vld       <= 1'b0;
      nice_req_inst <= '0;
      nice_req_rs1  <= '0;
      nice_req_rs2  <= '0;
    end else if (fire) begin
      req_vld       <= 1'b1;
      nice_req_inst <= i_instr;
      nice_req_rs1  <= i_rs1;
      nice_req_rs2  <= i_rs2;
    end else if (req_hs) begin
      req_vld       <= 1'b0;
    end
  end

  assign nice_req_valid = req_vld;

  e603_nice_tag_fifo #(
    .DEPTH (OUTS_DEPTH),
    .DW    (ITAG_W + 1)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fire),
    .pop   (rsp_hs),
    .wdata ({i_itag, i_rd_en}),
    .rdata (fifo_head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_wbck_valid   = nice_rsp_valid & ~fifo_empty;
  assign nice_rsp_ready = o_wbck_ready & ~fifo_empty;
  assign o_wbck_wdat    = nice_rsp_rdat;
  assign o_wbck_err     = nice_rsp_err;
  assign o_wbck_itag    = fifo_head[ITAG_W:1];
  assign o_wbck_rd_en   = fifo_head[0];
  assign o_nice_busy    = ~idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (i_drain_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!i_drain_req) state_d = ST_RUN;
        else if (idle)    state_d = ST_DONE;
      end
      ST_DONE:  if (!i_drain_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign o_drain_done = (state_q == ST_DONE);

`ifdef E603_NICE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_cnt;

  // Watchdog restarts on every retire; the flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt        <= '0;
      o_nice_timeout <= 1'b0;
    end else begin
      if (fifo_empty || rsp_hs)                  tmo_cnt <= '0;
      else if (tmo_cnt != TMO_W'(TIMEOUT_CYC-1)) tmo_cnt <= tmo_cnt + 1'b1;
      if (!fifo_empty && !rsp_hs && tmo_cnt == TMO_W'(TIMEOUT_CYC-1))
        o_nice_timeout <= 1'b1;
    end
  end

  assign tmo_block = o_nice_timeout;
`else
  assign tmo_block = 1'b0;
`endif

endmodule

// File: tb/tb_e603_exu_nice_ctrl.sv
// Self-checking bench for e603_exu_nice_ctrl: vector table, directed corner sequences, random vs queue model.
module tb_e603_exu_nice_ctrl;

  localparam int XLEN  = 32;
  localparam int ITW   = 3;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_valid, i_ready;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_rs1, i_rs2;
  logic [ITW-1:0]  i_itag;
  logic            i_rd_en;
  logic            nice_req_valid, nice_req_ready;
  logic [31:0]     nice_req_inst;
  logic [XLEN-1:0] nice_req_rs1, nice_req_rs2;
  logic            nice_rsp_valid, nice_rsp_ready;
  logic [XLEN-1:0] nice_rsp_rdat;
  logic            nice_rsp_err;
  logic            o_wbck_valid, o_wbck_ready;
  logic [XLEN-1:0] o_wbck_wdat;
  logic [ITW-1:0]  o_wbck_itag;
  logic            o_wbck_rd_en, o_wbck_err;
  logic            i_drain_req, o_drain_done, o_nice_busy;
`ifdef E603_NICE_TIMEOUT_EN
  logic            o_nice_timeout;
`endif

  always #5 clk = ~clk;

  e603_exu_nice_ctrl #(
    .XLEN(XLEN), .ITAG_W(ITW), .OUTS_DEPTH(DEPTH)
`ifdef E603_NICE_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_itag(i_itag), .i_rd_en(i_rd_en),
    .nice_req_valid(nice_req_valid), .nice_req_ready(nice_req_ready),
    .nice_req_inst(nice_req_inst), .nice_req_rs1(nice_req_rs1), .nice_req_rs2(nice_req_rs2),
    .nice_rsp_valid(nice_rsp_valid), .nice_rsp_ready(nice_rsp_ready),
    .nice_rsp_rdat(nice_rsp_rdat), .nice_rsp_err(nice_rsp_err),
    .o_wbck_valid(o_wbck_valid), .o_wbck_ready(o_wbck_ready), .o_wbck_wdat(o_wbck_wdat),
    .o_wbck_itag(o_wbck_itag), .o_wbck_rd_en(o_wbck_rd_en), .o_wbck_err(o_wbck_err),
    .i_drain_req(i_drain_req), .o_drain_done(o_drain_done), .o_nice_busy(o_nice_busy)
`ifdef E603_NICE_TIMEOUT_EN
    , .o_nice_timeout(o_nice_timeout)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    i_valid = 0; i_instr = '0; i_rs1 = '0; i_rs2 = '0; i_itag = '0; i_rd_en = 0;
    nice_req_ready = 0; nice_rsp_valid = 0; nice_rsp_rdat = '0; nice_rsp_err = 0;
    o_wbck_ready = 0; i_drain_req = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic offer(input logic [ITW-1:0] tag, input logic rd, input logic [31:0] a, input logic [31:0] b);
    i_valid = 1; i_itag = tag; i_rd_en = rd; i_rs1 = a; i_rs2 = b;
    i_instr = {17'h0, rd, 7'h0, 7'h0b};
  endtask

  typedef struct {
    logic iv; logic [ITW-1:0] itag; logic rd; logic rq_rdy; logic rsp_v; logic wb_rdy;
    logic e_irdy; logic e_reqv; logic e_wbv; logic e_rsprdy; logic [ITW-1:0] e_itag; logic e_busy;
  } vec_t;
  vec_t vecs[8];

  typedef struct packed { logic [31:0] inst; logic [31:0] rs1; logic [31:0] rs2; } req_t;
  typedef struct packed { logic [ITW-1:0] itag; logic rd; } tag_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int n;
    req_t rq[$];
    tag_t tq[$];
    int issued;
    logic exp_rdy, fire_m;

    // iv itag rd rq_rdy rsp_v wb_rdy | irdy reqv wbv rsprdy itag busy
    vecs[0] = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 2, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1};
    vecs[3] = '{0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 1};
    vecs[4] = '{0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 2, 1};
    vecs[5] = '{0, 0, 0, 0, 1, 1,  1, 0, 1, 1, 2, 1};
    vecs[6] = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
    vecs[7] = '{0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0};

    rst_n = 0;
    idle_in();
    #2;
    chk("rst_i_ready", i_ready, 1);
    chk("rst_req_valid", nice_req_valid, 0);
    chk("rst_wbck_valid", o_wbck_valid, 0);
    chk("rst_drain_done", o_drain_done, 0);
    chk("rst_busy", o_nice_busy, 0);
    do_reset();

    // vector table
    for (int v = 0; v < 8; v++) begin
      idle_in();
      i_valid = vecs[v].iv; i_itag = vecs[v].itag; i_rd_en = vecs[v].rd;
      nice_req_ready = vecs[v].rq_rdy; nice_rsp_valid = vecs[v].rsp_v; o_wbck_ready = vecs[v].wb_rdy;
      #1;
      chk($sformatf("vec%0d_i_ready", v), i_ready, vecs[v].e_irdy);
      chk($sformatf("vec%0d_req_valid", v), nice_req_valid, vecs[v].e_reqv);
      chk($sformatf("vec%0d_wbck_valid", v), o_wbck_valid, vecs[v].e_wbv);
      chk($sformatf("vec%0d_rsp_ready", v), nice_rsp_ready, vecs[v].e_rsprdy);
      chk($sformatf("vec%0d_busy", v), o_nice_busy, vecs[v].e_busy);
      if (vecs[v].e_wbv) chk($sformatf("vec%0d_itag", v), o_wbck_itag, vecs[v].e_itag);
      step();
    end

    // single op
    do_reset();
    offer(2, 1, 5, 7);
    nice_req_ready = 1;
    #1 chk("single_i_ready", i_ready, 1);
    step();
    idle_in(); nice_req_ready = 1;
    #1;
    chk("single_req_valid", nice_req_valid, 1);
    chk("single_req_rs1", nice_req_rs1, 5);
    chk("single_req_rs2", nice_req_rs2, 7);
    chk("single_req_inst", nice_req_inst, 32'h0000_400b);
    step();
    chk("single_req_cleared", nice_req_valid, 0);
    step(); step();
    nice_rsp_valid = 1; nice_rsp_rdat = 12; o_wbck_ready = 1;
    #1;
    chk("single_wbck_valid", o_wbck_valid, 1);
    chk("single_wbck_wdat", o_wbck_wdat, 12);
    chk("single_wbck_itag", o_wbck_itag, 2);
    chk("single_wbck_rd_en", o_wbck_rd_en, 1);
    chk("single_wbck_err", o_wbck_err, 0);
    chk("single_rsp_ready", nice_rsp_ready, 1);
    step();
    idle_in();
    #1 chk("single_busy_after", o_nice_busy, 0);

    // back-to-back fill, no bypass when full, in-order retire
    do_reset();
    nice_req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      offer(3'(k), 1, 32'(100 + k), 32'(200 + k));
      #1;
      chk($sformatf("b2b%0d_i_ready", k), i_ready, 1);
      if (k > 0) begin
        chk($sformatf("b2b%0d_req_valid", k), nice_req_valid, 1);
        chk($sformatf("b2b%0d_req_rs1", k), nice_req_rs1, 32'(100 + k - 1));
      end
      step();
    end
    offer(5, 0, 555, 0);
    #1;
    chk("b2b_full_i_ready", i_ready, 0);
    chk("b2b_4th_req_valid", nice_req_valid, 1);
    chk("b2b_4th_req_rs1", nice_req_rs1, 103);
    step();
    nice_rsp_valid = 1; o_wbck_ready = 1; nice_rsp_rdat = 77;
    #1;
    chk("b2b_full_pop_no_bypass", i_ready, 0);
    chk("b2b_head_itag", o_wbck_itag, 0);
    step();
    nice_rsp_valid = 0;
    #1 chk("b2b_5th_i_ready", i_ready, 1);
    step();
    i_valid = 0;
    nice_rsp_valid = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("b2b_retire%0d_itag", k), o_wbck_itag, (k < 3) ? 32'(k + 1) : 32'd5);
      chk($sformatf("b2b_retire%0d_rd_en", k), o_wbck_rd_en, (k < 3) ? 32'd1 : 32'd0);
      step();
    end
    nice_rsp_valid = 0;
    #1 chk("b2b_idle_busy", o_nice_busy, 0);

    // ordering with writeback backpressure
    do_reset();
    nice_req_ready = 1;
    for (int k = 1; k <= 3; k++) begin
      offer(3'(k), 1, 0, 0);
      step();
    end
    i_valid = 0;
    step();
    nice_rsp_valid = 1; o_wbck_ready = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("bp%0d_rsp_ready", c), nice_rsp_ready, 0);
      chk($sformatf("bp%0d_wbck_itag", c), o_wbck_itag, 1);
      step();
    end
    o_wbck_ready = 1;
    for (int k = 1; k <= 3; k++) begin
      nice_rsp_rdat = 32'(k * 11);
      #1;
      chk($sformatf("ord%0d_itag", k), o_wbck_itag, k);
      chk($sformatf("ord%0d_wdat", k), o_wbck_wdat, k * 11);
      step();
    end
    nice_rsp_valid = 0;

    // rd_en=0 with error completion
    do_reset();
    nice_req_ready = 1;
    offer(6, 0, 1, 2);
    step();
    i_valid = 0;
    step();
    nice_rsp_valid = 1; nice_rsp_err = 1; o_wbck_ready = 1;
    #1;
    chk("err_wbck_valid", o_wbck_valid, 1);
    chk("err_wbck_rd_en", o_wbck_rd_en, 0);
    chk("err_wbck_err", o_wbck_err, 1);
    chk("err_wbck_itag", o_wbck_itag, 6);
    step();
    idle_in();

    // drain handshake
    do_reset();
    nice_req_ready = 1;
    offer(1, 1, 0, 0); step();
    offer(2, 1, 0, 0); step();
    i_valid = 0; step();
    i_drain_req = 1;
    step();
    chk("drain_i_ready", i_ready, 0);
    chk("drain_not_done", o_drain_done, 0);
    nice_rsp_valid = 1; o_wbck_ready = 1;
    step();
    chk("drain_mid_not_done", o_drain_done, 0);
    step();
    nice_rsp_valid = 0;
    n = 0;
    while (!o_drain_done && n < 4) begin
      step();
      n++;
    end
    chk("drain_done", o_drain_done, 1);
    chk("drain_done_i_ready", i_ready, 0);
    i_drain_req = 0;
    step();
    chk("drain_release_i_ready", i_ready, 1);
    chk("drain_release_done", o_drain_done, 0);

    // reset mid-operation
    offer(4, 1, 9, 9);
    nice_req_ready = 0;
    step();
    i_valid = 0;
    rst_n = 0;
    #1;
    chk("midrst_req_valid", nice_req_valid, 0);
    chk("midrst_busy", o_nice_busy, 0);
    chk("midrst_i_ready", i_ready, 1);
    rst_n = 1;
    step();

`ifdef E603_NICE_TIMEOUT_EN
    do_reset();
    nice_req_ready = 1;
    offer(3, 1, 0, 0);
    step();
    i_valid = 0;
    n = 0;
    while (!o_nice_timeout && n < 40) begin
      step();
      n++;
    end
    chk("tmo_cycles", n, 16);
    i_valid = 1;
    #1 chk("tmo_i_ready", i_ready, 0);
    i_valid = 0;
    rst_n = 0;
    #1 chk("tmo_reset_clear", o_nice_timeout, 0);
    rst_n = 1;
    step();
`endif

    // random traffic against queue model
    do_reset();
    issued = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_valid = $urandom_range(0, 1);
      i_rs1 = $urandom; i_rs2 = $urandom; i_instr = $urandom;
      i_rd_en = i_instr[14]; i_itag = 3'($urandom);
      nice_req_ready = ($urandom_range(0, 2) != 0);
      nice_rsp_valid = (issued > 0) && ($urandom_range(0, 1) == 1);
      nice_rsp_rdat = $urandom; nice_rsp_err = $urandom_range(0, 1);
      o_wbck_ready = ($urandom_range(0, 3) != 0);
      exp_rdy = (tq.size() < DEPTH) && (rq.size() == 0 || nice_req_ready);
      #1;
      chk("rnd_i_ready", i_ready, exp_rdy);
      chk("rnd_req_valid", nice_req_valid, rq.size() != 0);
      if (rq.size() != 0) begin
        chk("rnd_req_inst", nice_req_inst, rq[0].inst);
        chk("rnd_req_rs1", nice_req_rs1, rq[0].rs1);
        chk("rnd_req_rs2", nice_req_rs2, rq[0].rs2);
      end
      chk("rnd_wbck_valid", o_wbck_valid, nice_rsp_valid && tq.size() != 0);
      chk("rnd_rsp_ready", nice_rsp_ready, o_wbck_ready && tq.size() != 0);
      chk("rnd_busy", o_nice_busy, rq.size() != 0 || tq.size() != 0);
      if (nice_rsp_valid && tq.size() != 0) begin
        chk("rnd_wbck_itag", o_wbck_itag, tq[0].itag);
        chk("rnd_wbck_rd_en", o_wbck_rd_en, tq[0].rd);
        chk("rnd_wbck_wdat", o_wbck_wdat, nice_rsp_rdat);
        chk("rnd_wbck_err", o_wbck_err, nice_rsp_err);
      end
      if (rq.size() != 0 && nice_req_ready) begin
        void'(rq.pop_front());
        issued++;
      end
      if (nice_rsp_valid && o_wbck_ready && tq.size() != 0) begin
        void'(tq.pop_front());
        issued--;
      end
      fire_m = i_valid && exp_rdy;
      if (fire_m) begin
        rq.push_back('{inst: i_instr, rs1: i_rs1, rs2: i_rs2});
        tq.push_back('{itag: i_itag, rd: i_rd_en});
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
